noc_local_injector: RTL and testbench

Credit-based flit transmitter that drives the LOCAL input port of a mesh router in the manycore. It takes a packet request (destination address, payload length) plus a stream of payload words buffered in an internal FIFO, and serializes them as Hermes-style flits: header, size, then payload. It is the sending end of the same tx/data/credit link that the mesh uses between neighbouring routers.

---
 rtl/noc_pkg.sv | 27 ++
 rtl/flit_fifo.sv | 67 ++++++
 rtl/noc_local_injector.sv | 173 +++++++++++++++++
 tb/tb_noc_local_injector.sv | 469 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: router port numbering, injector FSM states and
// router address packing.
package noc_pkg;

    typedef enum logic [2:0] {
        EAST  = 3'd0,
        WEST  = 3'd1,
        NORTH = 3'd2,
        SOUTH = 3'd3,
        LOCAL = 3'd4
    } port_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HEADER  = 3'd1,
        SIZE    = 3'd2,
        PAYLOAD = 3'd3,
        DONE    = 3'd4
    } inj_state_e;

    localparam int ADDR_W = 16;

    function automatic logic [ADDR_W-1:0] pack_addr(input logic [7:0] x, input logic [7:0] y);
        return {x, y};
    endfunction

endpackage

// File: rtl/flit_fifo.sv
// Synchronous flit FIFO with an extra-bit occupancy counter; exposes the head
// word and the word behind it so a registered consumer can pop and reload at once.
module flit_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [WIDTH-1:0]         next_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    // A push is refused while full even if a pop happens in the same cycle.
    assign full      = (r_count == CNT_FULL);
    assign empty     = (r_count == {(AW + 1){1'b0}});
    assign count     = r_count;
    assign w_push_ok = push & ~full;
    assign w_pop_ok  = pop & ~empty;
    assign head_data = r_mem[r_rd_ptr];
    assign next_data = r_mem[r_rd_ptr + PTR_ONE];

    // Storage array write port.
    always_ff @(posedge clock) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {(AW + 1){1'b0}};
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/noc_local_injector.sv
// Credit-based transmitter feeding a router LOCAL port: emits header, size and
// payload flits, taking payload words from a free-running FIFO.
module noc_local_injector
    import noc_pkg::*;
#(
    parameter int FLIT_WIDTH = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  send_start,
    input  logic [15:0]           send_dest,
    input  logic [15:0]           send_len,
    output logic                  send_busy,
    input  logic [FLIT_WIDTH-1:0] word_i,
    input  logic                  word_valid_i,
    output logic                  word_ready_o,
    output logic                  tx,
    output logic [FLIT_WIDTH-1:0] data_o,
    input  logic                  credit_i,
    output logic                  clock_tx,
    output logic                  pkt_done
);
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int PAD = FLIT_WIDTH - 16;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    inj_state_e            r_state;
    inj_state_e            w_state_nxt;
    logic [15:0]           r_dest;
    logic [15:0]           r_len;
    logic [15:0]           r_cnt;
    logic [15:0]           w_dest_nxt;
    logic [15:0]           w_len_nxt;
    logic [15:0]           w_cnt_nxt;
    logic                  r_tx;
    logic                  w_tx_nxt;
    logic                  r_pkt_done;
    logic                  w_pkt_done_nxt;
    logic [FLIT_WIDTH-1:0] r_data;
    logic [FLIT_WIDTH-1:0] w_data_nxt;
    logic                  w_xfer;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic [FLIT_WIDTH-1:0] w_head;
    logic [FLIT_WIDTH-1:0] w_next;
    logic [CW-1:0]         w_count;

    assign w_xfer       = r_tx & credit_i;
    assign word_ready_o = ~w_full;
    assign send_busy    = (r_state != IDLE);
    assign tx           = r_tx;
    assign data_o       = r_data;
    assign pkt_done     = r_pkt_done;
    assign clock_tx     = clock;

    flit_fifo #(
        .WIDTH (FLIT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (word_valid_i),
        .push_data (word_i),
        .pop       (w_pop),
        .head_data (w_head),
        .next_data (w_next),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    // Next-state and next-output logic; the presented payload word stays in the
    // FIFO until it is accepted, and the word behind it is loaded on that edge.
    always_comb begin
        w_state_nxt    = r_state;
        w_dest_nxt     = r_dest;
        w_len_nxt      = r_len;
        w_cnt_nxt      = r_cnt;
        w_tx_nxt       = r_tx;
        w_data_nxt     = r_data;
        w_pkt_done_nxt = 1'b0;
        w_pop          = 1'b0;
        case (r_state)
            IDLE: begin
                if (send_start) begin
                    w_state_nxt = HEADER;
                    w_dest_nxt  = send_dest;
                    w_len_nxt   = send_len;
                    w_cnt_nxt   = 16'd0;
                    w_tx_nxt    = 1'b1;
                    w_data_nxt  = {{PAD{1'b0}}, send_dest};
                end else begin
                    w_tx_nxt = 1'b0;
                end
            end
            HEADER: begin
                if (w_xfer) begin
                    w_state_nxt = SIZE;
                    w_tx_nxt    = 1'b1;
                    w_data_nxt  = {{PAD{1'b0}}, r_len};
                end else begin
                    w_tx_nxt = r_tx;
                end
            end
            SIZE: begin
                if (w_xfer && (r_len == 16'd0)) begin
                    w_state_nxt    = DONE;
                    w_tx_nxt       = 1'b0;
                    w_pkt_done_nxt = 1'b1;
                end else if (w_xfer) begin
                    w_state_nxt = PAYLOAD;
                    w_tx_nxt    = ~w_empty;
                    w_data_nxt  = w_head;
                end else begin
                    w_tx_nxt = r_tx;
                end
            end
            PAYLOAD: begin
                if (w_xfer) begin
                    w_pop     = 1'b1;
                    w_cnt_nxt = r_cnt + 16'd1;
                    if (r_cnt == (r_len - 16'd1)) begin
                        w_state_nxt    = DONE;
                        w_tx_nxt       = 1'b0;
                        w_pkt_done_nxt = 1'b1;
                    end else if (w_count > CNT_ONE) begin
                        w_tx_nxt   = 1'b1;
                        w_data_nxt = w_next;
                    end else begin
                        w_tx_nxt = 1'b0;
                    end
                end else if (!r_tx && !w_empty) begin
                    w_tx_nxt   = 1'b1;
                    w_data_nxt = w_head;
                end else begin
                    w_tx_nxt = r_tx;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
                w_tx_nxt    = 1'b0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_tx_nxt    = 1'b0;
            end
        endcase
    end

    // State and registered output update.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_dest     <= 16'd0;
            r_len      <= 16'd0;
            r_cnt      <= 16'd0;
            r_tx       <= 1'b0;
            r_data     <= {FLIT_WIDTH{1'b0}};
            r_pkt_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_dest     <= w_dest_nxt;
            r_len      <= w_len_nxt;
            r_cnt      <= w_cnt_nxt;
            r_tx       <= w_tx_nxt;
            r_data     <= w_data_nxt;
            r_pkt_done <= w_pkt_done_nxt;
        end
    end

endmodule

// File: tb/tb_noc_local_injector.sv
// Bench for noc_local_injector: directed scenarios plus random traffic against
// a packet-level scoreboard (expected flits = dest, len, then FIFO words in order).
module tb_noc_local_injector;

    logic        clock = 1'b0;
    logic        reset;
    logic        send_start;
    logic [15:0] send_dest;
    logic [15:0] send_len;
    logic        send_busy;
    logic [31:0] word_i;
    logic        word_valid_i;
    logic        word_ready_o;
    logic        tx;
    logic [31:0] data_o;
    logic        credit_i;
    logic        clock_tx;
    logic        pkt_done;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] m_q[$];
    logic        m_armed = 1'b0;
    logic        m_busy  = 1'b0;
    logic        m_done  = 1'b0;
    logic [15:0] m_dest  = 16'h0000;
    logic [15:0] m_len   = 16'h0000;
    int          m_idx   = 0;
    int          m_xfers = 0;
    int          last_xfers = 0;
    logic        p_tx = 1'b0;
    logic        p_credit = 1'b0;
    logic        p_reset = 1'b1;
    logic [31:0] p_data = 32'h0;

    always #5 clock = ~clock;

    noc_local_injector #(.FLIT_WIDTH(32), .FIFO_DEPTH(16)) dut (
        .clock        (clock),
        .reset        (reset),
        .send_start   (send_start),
        .send_dest    (send_dest),
        .send_len     (send_len),
        .send_busy    (send_busy),
        .word_i       (word_i),
        .word_valid_i (word_valid_i),
        .word_ready_o (word_ready_o),
        .tx           (tx),
        .data_o       (data_o),
        .credit_i     (credit_i),
        .clock_tx     (clock_tx),
        .pkt_done     (pkt_done)
    );

    // Scoreboard: checks outputs against the model, then applies the events
    // that the next rising edge will perform.
    always @(negedge clock) begin : scoreboard
        logic        was_busy;
        logic        done_n;
        logic        push_ok;
        logic        exp_rdy;
        logic [31:0] exp_w;
        exp_rdy = (m_q.size() < 16) ? 1'b1 : 1'b0;
        if (m_armed) begin
            checks++;
            if (word_ready_o !== exp_rdy) begin
                failures++;
                $display("FAIL sb_ready: got %b expected %b", word_ready_o, exp_rdy);
            end
            checks++;
            if (send_busy !== m_busy) begin
                failures++;
                $display("FAIL sb_busy: got %b expected %b", send_busy, m_busy);
            end
            checks++;
            if (pkt_done !== m_done) begin
                failures++;
                $display("FAIL sb_pkt_done: got %b expected %b", pkt_done, m_done);
            end
            if (!m_busy) begin
                checks++;
                if (tx !== 1'b0) begin
                    failures++;
                    $display("FAIL sb_idle_tx: got %b expected 0", tx);
                end
            end
            if (p_tx && !p_credit && !p_reset) begin
                checks++;
                if (tx !== 1'b1 || data_o !== p_data) begin
                    failures++;
                    $display("FAIL sb_stall_hold: got tx=%b data=%h expected tx=1 data=%h", tx, data_o, p_data);
                end
            end
        end
        if (reset === 1'b1) begin
            m_q.delete();
            m_busy  = 1'b0;
            m_done  = 1'b0;
            m_idx   = 0;
            m_xfers = 0;
            m_armed = 1'b1;
        end else if (m_armed) begin
            push_ok = word_valid_i && exp_rdy;
            done_n  = 1'b0;
            if (tx === 1'b1 && credit_i === 1'b1) begin
                if (!m_busy || m_idx > m_len + 1) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_extra_flit: got %h expected no transfer", data_o);
                end else if (m_idx >= 2 && m_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_underrun: got %h expected no payload (model FIFO empty)", data_o);
                end else begin
                    if (m_idx == 0) exp_w = {16'h0000, m_dest};
                    else if (m_idx == 1) exp_w = {16'h0000, m_len};
                    else exp_w = m_q.pop_front();
                    checks++;
                    if (data_o !== exp_w) begin
                        failures++;
                        $display("FAIL sb_flit[%0d]: got %h expected %h", m_idx, data_o, exp_w);
                    end
                    if (m_idx == m_len + 1) done_n = 1'b1;
                    m_idx++;
                    m_xfers++;
                end
            end
            if (push_ok) m_q.push_back(word_i);
            was_busy = m_busy;
            if (m_done) m_busy = 1'b0;
            if (!was_busy && send_start === 1'b1) begin
                m_busy  = 1'b1;
                m_dest  = send_dest;
                m_len   = send_len;
                m_idx   = 0;
                m_xfers = 0;
            end
            if (done_n) last_xfers = m_xfers;
            m_done = done_n;
        end
        p_tx     = tx;
        p_credit = credit_i;
        p_reset  = reset;
        p_data   = data_o;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_pkt(input logic [15:0] dest, input logic [15:0] len);
        int n = 0;
        while (send_busy === 1'b1 && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (send_busy !== 1'b0) begin
            failures++;
            $display("FAIL start_wait: got busy=%b expected 0 within 200 cycles", send_busy);
        end
        send_dest  = dest;
        send_len   = len;
        send_start = 1'b1;
        tick();
        send_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rnd, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            if (rnd) begin
                credit_i     = ($urandom_range(0, 3) != 0);
                word_valid_i = $urandom_range(0, 1);
                word_i       = $urandom;
            end
            tick();
            if (pkt_done === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        checks++;
        if (tx !== 1'b0 || data_o !== 32'h0 || send_busy !== 1'b0 || pkt_done !== 1'b0 || word_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_values: got tx=%b data=%h busy=%b done=%b ready=%b expected 0 0 0 0 1",
                     tx, data_o, send_busy, pkt_done, word_ready_o);
        end
        checks++;
        if (clock_tx !== clock) begin
            failures++;
            $display("FAIL clock_tx: got %b expected %b", clock_tx, clock);
        end
        tick();
        checks++;
        if (tx !== 1'b0 || send_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: got tx=%b busy=%b expected 0 0", tx, send_busy);
        end
    endtask

    task automatic test_basic();
        logic [31:0] exp_seq [5];
        exp_seq = '{32'h00000101, 32'h00000003, 32'h000000A0, 32'h000000A1, 32'h000000A2};
        credit_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            word_valid_i = 1'b1;
            word_i       = 32'hA0 + i;
            tick();
        end
        word_valid_i = 1'b0;
        send_dest = 16'h0101;
        send_len  = 16'd3;
        send_start = 1'b1;
        tick();
        send_start = 1'b0;
        for (int j = 0; j < 5; j++) begin
            checks++;
            if (tx !== 1'b1 || data_o !== exp_seq[j]) begin
                failures++;
                $display("FAIL basic_flit%0d: got tx=%b data=%h expected tx=1 data=%h", j, tx, data_o, exp_seq[j]);
            end
            tick();
        end
        checks++;
        if (pkt_done !== 1'b1 || tx !== 1'b0) begin
            failures++;
            $display("FAIL basic_done: got done=%b tx=%b expected 1 0", pkt_done, tx);
        end
        tick();
        checks++;
        if (pkt_done !== 1'b0 || send_busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_after: got done=%b busy=%b expected 0 0", pkt_done, send_busy);
        end
    endtask

    task automatic test_credit_stall();
        bit ok;
        credit_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            word_valid_i = 1'b1;
            word_i       = 32'hB0 + i;
            tick();
        end
        word_valid_i = 1'b0;
        start_pkt(16'h0101, 16'd3);
        tick();
        credit_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (tx !== 1'b1 || data_o !== 32'h3) begin
                failures++;
                $display("FAIL stall_size%0d: got tx=%b data=%h expected tx=1 data=00000003", k, tx, data_o);
            end
        end
        credit_i = 1'b1;
        wait_done(50, 1'b0, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL stall_timeout: got no pkt_done expected pkt_done within 50 cycles");
        end
        checks++;
        if (last_xfers != 5) begin
            failures++;
            $display("FAIL stall_count: got %0d flits expected 5", last_xfers);
        end
    endtask

    task automatic test_zero_len();
        credit_i = 1'b1;
        start_pkt(16'h0203, 16'd0);
        checks++;
        if (tx !== 1'b1 || data_o !== 32'h00000203) begin
            failures++;
            $display("FAIL zero_header: got tx=%b data=%h expected tx=1 data=00000203", tx, data_o);
        end
        send_dest  = 16'h0F0F;
        send_len   = 16'd5;
        send_start = 1'b1;
        tick();
        checks++;
        if (tx !== 1'b1 || data_o !== 32'h0) begin
            failures++;
            $display("FAIL zero_size: got tx=%b data=%h expected tx=1 data=00000000", tx, data_o);
        end
        tick();
        checks++;
        if (pkt_done !== 1'b1 || tx !== 1'b0) begin
            failures++;
            $display("FAIL zero_done: got done=%b tx=%b expected 1 0", pkt_done, tx);
        end
        tick();
        send_start = 1'b0;
        checks++;
        if (send_busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_ignored_start: got busy=%b expected 0", send_busy);
        end
        tick();
        checks++;
        if (send_busy !== 1'b0 || tx !== 1'b0) begin
            failures++;
            $display("FAIL zero_idle: got busy=%b tx=%b expected 0 0", send_busy, tx);
        end
    endtask

    task automatic test_bubbles();
        int  bubbles = 0;
        int  pushed  = 0;
        int  cyc     = 0;
        bit  seen    = 1'b0;
        credit_i = 1'b1;
        start_pkt(16'h0302, 16'd2);
        while (!seen && cyc < 200) begin
            word_valid_i = (cyc % 3 == 2) && (pushed < 2);
            word_i       = 32'hB00 + pushed;
            if (word_valid_i) pushed++;
            tick();
            cyc++;
            if (send_busy === 1'b1 && tx === 1'b0 && pkt_done === 1'b0) bubbles++;
            if (pkt_done === 1'b1) seen = 1'b1;
        end
        word_valid_i = 1'b0;
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL bubble_timeout: got no pkt_done expected pkt_done within 200 cycles");
        end
        checks++;
        if (bubbles == 0) begin
            failures++;
            $display("FAIL bubble_seen: got %0d bubble cycles expected at least 1", bubbles);
        end
        checks++;
        if (last_xfers != 4) begin
            failures++;
            $display("FAIL bubble_count: got %0d flits expected 4", last_xfers);
        end
    endtask

    task automatic test_full();
        bit ok;
        credit_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            word_valid_i = 1'b1;
            word_i       = 32'hC0 + i;
            tick();
        end
        checks++;
        if (word_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL full_ready: got %b expected 0", word_ready_o);
        end
        word_i = 32'hDEAD;
        tick();
        word_valid_i = 1'b0;
        checks++;
        if (word_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL full_refuse: got %b expected 0", word_ready_o);
        end
        start_pkt(16'h0404, 16'd4);
        wait_done(100, 1'b0, ok);
        checks++;
        if (!ok || last_xfers != 6) begin
            failures++;
            $display("FAIL full_len4: got done=%b flits=%0d expected 1 6", ok, last_xfers);
        end
        checks++;
        if (word_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL full_after4: got ready=%b expected 1", word_ready_o);
        end
        start_pkt(16'h0405, 16'd12);
        wait_done(100, 1'b0, ok);
        checks++;
        if (!ok || last_xfers != 14) begin
            failures++;
            $display("FAIL full_len12: got done=%b flits=%0d expected 1 14", ok, last_xfers);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        credit_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            word_valid_i = 1'b1;
            word_i       = 32'hD0 + i;
            tick();
        end
        word_valid_i = 1'b0;
        start_pkt(16'h0505, 16'd4);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (tx !== 1'b0 || send_busy !== 1'b0 || word_ready_o !== 1'b1 || pkt_done !== 1'b0 || data_o !== 32'h0) begin
            failures++;
            $display("FAIL midreset: got tx=%b busy=%b ready=%b done=%b data=%h expected 0 0 1 0 0",
                     tx, send_busy, word_ready_o, pkt_done, data_o);
        end
        start_pkt(16'h0606, 16'd1);
        repeat (5) tick();
        checks++;
        if (tx !== 1'b0 || send_busy !== 1'b1) begin
            failures++;
            $display("FAIL midreset_empty: got tx=%b busy=%b expected 0 1", tx, send_busy);
        end
        word_valid_i = 1'b1;
        word_i       = 32'hE0;
        tick();
        word_valid_i = 1'b0;
        wait_done(20, 1'b0, ok);
        checks++;
        if (!ok || last_xfers != 3) begin
            failures++;
            $display("FAIL midreset_next: got done=%b flits=%0d expected 1 3", ok, last_xfers);
        end
    endtask

    task automatic test_random();
        bit          ok;
        logic [15:0] len;
        for (int p = 0; p < 25; p++) begin
            len = 16'($urandom_range(0, 12));
            start_pkt(16'($urandom), len);
            wait_done(800, 1'b1, ok);
            checks++;
            if (!ok || last_xfers != int'(len) + 2) begin
                failures++;
                $display("FAIL random_pkt%0d: got done=%b flits=%0d expected 1 %0d", p, ok, last_xfers, int'(len) + 2);
            end
        end
        word_valid_i = 1'b0;
        credit_i     = 1'b1;
    endtask

    initial begin
        reset        = 1'b1;
        send_start   = 1'b0;
        send_dest    = 16'h0;
        send_len     = 16'h0;
        word_i       = 32'h0;
        word_valid_i = 1'b0;
        credit_i     = 1'b1;
        test_reset();
        test_basic();
        test_credit_stall();
        test_zero_len();
        test_bubbles();
        test_full();
        test_reset_mid();
        test_random();
        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
